// File: rtl/config_pkg.sv
// Shared configuration types for the interrupt nesting controller.
// Priority widths, depth type and nesting FSM states.
package config_pkg;

    localparam int PrioNum       = 8;
    localparam int PrioWidth     = $clog2(PrioNum);
    localparam int FlushCntWidth = 4;

    typedef logic [PrioWidth-1:0] PrioT;
    typedef logic [PrioWidth-1:0] DepthT;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        ENTER
    } NestStateT;

endpackage

// File: rtl/prio_nest_ctrl_lifo.sv
// prio_lifo: registered LIFO of priority levels.
// Simultaneous push+pop overwrites the top entry in place.
module prio_lifo
    import config_pkg::*;
#(
    parameter int Entries = PrioNum
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  PrioT  din,
    output PrioT  top,
    output DepthT depth
);

    PrioT  mem [Entries];
    DepthT depthQ;
    DepthT topIdx;

    assign topIdx = depthQ - DepthT'(1);

    // Storage write: replace top on push+pop, append on push alone.
    always_ff @(posedge clk) begin
        if (push && pop) begin
            mem[topIdx] <= din;
        end else if (push) begin
            mem[depthQ] <= din;
        end
    end

    // Occupancy count; unchanged when push and pop coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depthQ <= '0;
        end else if (push && !pop) begin
            depthQ <= depthQ + DepthT'(1);
        end else if (pop && !push && depthQ != '0) begin
            depthQ <= depthQ - DepthT'(1);
        end
    end

    assign top   = (depthQ == '0) ? '0 : mem[topIdx];
    assign depth = depthQ;

endmodule

// File: rtl/prio_nest_ctrl.sv
// Interrupt nesting controller: preemption, pipeline drain, level stack.
// Optional tail-chaining on return: define PRIO_NEST_TAIL_CHAIN_EN.
module prio_nest_ctrl
    import config_pkg::*;
#(
    parameter int FlushCycles = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  irq_valid_i,
    input  PrioT  irq_prio_i,
    input  logic  boundary_i,
    input  logic  ret_i,
    output PrioT  level_o,
    output logic  write_ra_en_o,
    output logic  irq_ack_o,
    output logic  flush_req_o,
    output DepthT depth_o,
    output logic  underflow_o
);

    typedef logic [FlushCntWidth-1:0] CntT;

    NestStateT state, stateNext;
    CntT       cnt, cntNext;
    PrioT      pendPrio, pendNext;
    PrioT      levelQ, levelNext;
    logic      underflowQ, underflowSet;

    logic  lifoPush, lifoPop;
    PrioT  lifoDin, lifoTop;
    DepthT depth;

    logic preempt;
    assign preempt = irq_valid_i && (irq_prio_i > levelQ);

    prio_lifo #(
        .Entries(PrioNum)
    ) uLifo (
        .clk  (clk),
        .reset(reset),
        .push (lifoPush),
        .pop  (lifoPop),
        .din  (lifoDin),
        .top  (lifoTop),
        .depth(depth)
    );

    // State, counter, pending level, current level and sticky underflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            cnt        <= '0;
            pendPrio   <= '0;
            levelQ     <= '0;
            underflowQ <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            pendPrio <= pendNext;
            levelQ   <= levelNext;
            if (underflowSet) begin
                underflowQ <= 1'b1;
            end
        end
    end

    // Next-state, stack control and pulse outputs.
    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        pendNext      = pendPrio;
        levelNext     = levelQ;
        underflowSet  = 1'b0;
        lifoPush      = 1'b0;
        lifoPop       = 1'b0;
        lifoDin       = lifoTop;
        write_ra_en_o = 1'b0;
        irq_ack_o     = 1'b0;
        flush_req_o   = 1'b0;
        unique case (state)
            RUN: begin
                if (ret_i) begin
                    if (depth == '0) begin
                        underflowSet = 1'b1;
                    end else begin
                        lifoPop   = 1'b1;
                        levelNext = lifoTop;
`ifdef PRIO_NEST_TAIL_CHAIN_EN
                        // Chain straight into the pending handler.
                        if (irq_valid_i && irq_prio_i > lifoTop) begin
                            lifoPush      = 1'b1;
                            lifoDin       = lifoTop;
                            levelNext     = irq_prio_i;
                            write_ra_en_o = 1'b1;
                            irq_ack_o     = 1'b1;
                        end
`endif
                    end
                end else if (preempt) begin
                    stateNext = FLUSH;
                    pendNext  = irq_prio_i;
                    cntNext   = CntT'(FlushCycles - 1);
                end
            end
            FLUSH: begin
                flush_req_o = 1'b1;
                if (ret_i) begin
                    stateNext = RUN;
                    if (depth == '0) begin
                        underflowSet = 1'b1;
                    end else begin
                        lifoPop   = 1'b1;
                        levelNext = lifoTop;
                    end
                end else if (!preempt) begin
                    stateNext = RUN;
                end else begin
                    if (irq_prio_i > pendPrio) begin
                        pendNext = irq_prio_i;
                    end
                    if (cnt != '0) begin
                        cntNext = cnt - CntT'(1);
                    end else if (boundary_i) begin
                        stateNext = ENTER;
                    end
                end
            end
            ENTER: begin
                lifoPush      = 1'b1;
                lifoDin       = levelQ;
                levelNext     = pendPrio;
                write_ra_en_o = 1'b1;
                irq_ack_o     = 1'b1;
                stateNext     = RUN;
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    assign level_o     = levelQ;
    assign depth_o     = depth;
    assign underflow_o = underflowQ;

    // Return is illegal while the pipeline is stalled in ENTER.
    aRetInEnter: assert property (
        @(posedge clk) disable iff (!reset)
        !(state == ENTER && ret_i)
    );

    // Levels strictly increase, so a push at a full stack is a bug.
    aNoOverflow: assert property (
        @(posedge clk) disable iff (!reset)
        !(lifoPush && !lifoPop && depth == DepthT'(PrioNum - 1))
    );

endmodule

// File: tb/tb_prio_nest_ctrl.sv
// Self-checking bench for prio_nest_ctrl: vector table,
// corner-case sequences and randomized run against a queue model.
module tb_prio_nest_ctrl;
    import config_pkg::*;

    localparam int FC = 2;

    logic  clk;
    logic  reset;
    logic  irqValid;
    PrioT  irqPrio;
    logic  boundary;
    logic  ret;
    PrioT  level;
    logic  wrRa;
    logic  ack;
    logic  flushReq;
    DepthT depth;
    logic  underflow;

    int nChecks;
    int nFails;

    prio_nest_ctrl #(
        .FlushCycles(FC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_valid_i  (irqValid),
        .irq_prio_i   (irqPrio),
        .boundary_i   (boundary),
        .ret_i        (ret),
        .level_o      (level),
        .write_ra_en_o(wrRa),
        .irq_ack_o    (ack),
        .flush_req_o  (flushReq),
        .depth_o      (depth),
        .underflow_o  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input int p,
                        input logic b, input logic r);
        @(negedge clk);
        irqValid = v;
        irqPrio  = PrioT'(p);
        boundary = b;
        ret      = r;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset    = 1'b0;
        irqValid = 1'b0;
        irqPrio  = '0;
        boundary = 1'b1;
        ret      = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic v;
        int   p;
        logic b;
        logic r;
        int   eLevel;
        int   eDepth;
        logic eFlush;
        logic eAck;
    } VecT;

    VecT vecs [17];

    // Behavioural model: phase 0=running 1=draining 2=entering.
    int mLevel;
    int mStack[$];
    int mPhase;
    int mWaited;
    int mPend;
    bit mUnder;

    task automatic modelReset();
        mLevel  = 0;
        mStack  = {};
        mPhase  = 0;
        mWaited = 0;
        mPend   = 0;
        mUnder  = 0;
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        reset    = 1'b0;
        irqValid = 1'b0;
        irqPrio  = '0;
        boundary = 1'b1;
        ret      = 1'b0;

        // Entry to 3, nested entry to 5 with boundary stalls,
        // non-preempting 4/5, then two returns down to thread mode.
        vecs[0]  = '{0, 0, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 3, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 3, 1, 0, 0, 0, 1, 0};
        vecs[3]  = '{1, 3, 1, 0, 0, 0, 1, 0};
        vecs[4]  = '{1, 3, 1, 0, 0, 0, 0, 1};
        vecs[5]  = '{0, 0, 1, 0, 3, 1, 0, 0};
        vecs[6]  = '{1, 5, 1, 0, 3, 1, 0, 0};
        vecs[7]  = '{1, 5, 1, 0, 3, 1, 1, 0};
        vecs[8]  = '{1, 5, 0, 0, 3, 1, 1, 0};
        vecs[9]  = '{1, 5, 0, 0, 3, 1, 1, 0};
        vecs[10] = '{1, 5, 1, 0, 3, 1, 1, 0};
        vecs[11] = '{1, 5, 1, 0, 3, 1, 0, 1};
        vecs[12] = '{1, 4, 1, 0, 5, 2, 0, 0};
        vecs[13] = '{1, 5, 1, 0, 5, 2, 0, 0};
        vecs[14] = '{0, 0, 1, 1, 5, 2, 0, 0};
        vecs[15] = '{0, 0, 1, 1, 3, 1, 0, 0};
        vecs[16] = '{0, 0, 1, 0, 0, 0, 0, 0};

        #1;
        chk("rst_level", level, 0);
        chk("rst_depth", depth, 0);
        chk("rst_flush", flushReq, 0);
        chk("rst_ack", ack, 0);
        chk("rst_wr", wrRa, 0);
        chk("rst_under", underflow, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].v, vecs[i].p, vecs[i].b, vecs[i].r);
            chk($sformatf("vec%0d_level", i), level, vecs[i].eLevel);
            chk($sformatf("vec%0d_depth", i), depth, vecs[i].eDepth);
            chk($sformatf("vec%0d_flush", i), flushReq, vecs[i].eFlush);
            chk($sformatf("vec%0d_ack", i), ack, vecs[i].eAck);
            chk($sformatf("vec%0d_wr", i), wrRa, vecs[i].eAck);
            chk($sformatf("vec%0d_under", i), underflow, 0);
        end

        // Return coinciding with a higher pending interrupt.
        doReset();
        for (int i = 0; i < 4; i++) step(1, 5, 1, 0);
        step(1, 6, 1, 1);
        chk("rc_level_before", level, 5);
`ifdef PRIO_NEST_TAIL_CHAIN_EN
        chk("rc_wr_in_ret", wrRa, 1);
        step(1, 6, 1, 0);
        chk("rc_level_chain", level, 6);
        chk("rc_depth_chain", depth, 1);
`else
        chk("rc_wr_in_ret", wrRa, 0);
        step(1, 6, 1, 0);
        chk("rc_level_pop", level, 0);
        chk("rc_depth_pop", depth, 0);
`endif
        for (int i = 0; i < 3; i++) step(1, 6, 1, 0);
        step(0, 0, 1, 0);
        chk("rc_level_final", level, 6);
        chk("rc_depth_final", depth, 1);

        // Withdrawn interrupt, then underflow stickiness.
        doReset();
        step(1, 4, 1, 0);
        step(1, 4, 1, 0);
        chk("wd_flush", flushReq, 1);
        step(0, 0, 1, 0);
        chk("wd_ack", ack, 0);
        step(0, 0, 1, 0);
        chk("wd_flush_off", flushReq, 0);
        chk("wd_level", level, 0);
        chk("wd_depth", depth, 0);
        chk("wd_wr", wrRa, 0);
        step(0, 0, 1, 1);
        chk("uf_pre", underflow, 0);
        step(0, 0, 1, 0);
        chk("uf_set", underflow, 1);
        chk("uf_level", level, 0);
        chk("uf_depth", depth, 0);
        for (int i = 0; i < 3; i++) step(1, 3, 1, 0);
        step(0, 0, 1, 0);
        chk("uf_sticky", underflow, 1);

        // Reset asserted during the ENTER cycle.
        doReset();
        for (int i = 0; i < 3; i++) step(1, 2, 1, 0);
        step(1, 2, 1, 0);
        chk("re_in_enter", ack, 1);
        reset = 1'b0;
        #1;
        chk("re_level", level, 0);
        chk("re_depth", depth, 0);
        chk("re_ack", ack, 0);
        chk("re_wr", wrRa, 0);
        chk("re_flush", flushReq, 0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 1, 0);
        chk("re_depth_after", depth, 0);

        // Randomized run against the model.
        doReset();
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            logic v, b, r;
            int   p;
            int   expAck;
            bit   chain;
            v = ($urandom_range(0, 9) < 6);
            p = $urandom_range(1, PrioNum - 1);
            b = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 7) == 0);
            if (mPhase == 2) r = 1'b0;
            step(v, p, b, r);

            chain = 0;
`ifdef PRIO_NEST_TAIL_CHAIN_EN
            if (mPhase == 0 && r && mStack.size() > 0 && v &&
                p > mStack[$]) chain = 1;
`endif
            expAck = (mPhase == 2 || chain) ? 1 : 0;
            chk("rnd_level", level, mLevel);
            chk("rnd_depth", depth, mStack.size());
            chk("rnd_flush", flushReq, (mPhase == 1) ? 1 : 0);
            chk("rnd_ack", ack, expAck);
            chk("rnd_wr", wrRa, expAck);
            chk("rnd_under", underflow, mUnder);

            if (mPhase == 0) begin
                if (r) begin
                    if (mStack.size() == 0) begin
                        mUnder = 1;
                    end else if (chain) begin
                        mLevel = p;
                    end else begin
                        mLevel = mStack.pop_back();
                    end
                end else if (v && p > mLevel) begin
                    mPhase  = 1;
                    mPend   = p;
                    mWaited = 0;
                end
            end else if (mPhase == 1) begin
                if (r) begin
                    if (mStack.size() == 0) mUnder = 1;
                    else mLevel = mStack.pop_back();
                    mPhase = 0;
                end else if (!(v && p > mLevel)) begin
                    mPhase = 0;
                end else begin
                    if (p > mPend) mPend = p;
                    if (mWaited >= FC - 1 && b) mPhase = 2;
                    else mWaited++;
                end
            end else begin
                mStack.push_back(mLevel);
                mLevel = mPend;
                mPhase = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
